// File: rtl/fetch_queue_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
// Parcels are 16-bit halves of fetch words; the low two bits classify the instruction length.
package fetch_pkg;

  localparam int PARCEL_W = 16;

  typedef logic [PARCEL_W-1:0] parcel_t;

  function automatic logic is_comp(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side handshake bundle of the prefetch queue.
// The slave modport is the queue itself; the master modport is its environment.
interface fetch_queue_if #(
  parameter int XLEN = 64
);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_data;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_inst;
  logic            out_comp;
  logic [XLEN-1:0] out_pc;
  logic            flush;
  logic [XLEN-1:0] flush_pc;

  modport slave (
    input  in_valid, in_data, out_ready, flush, flush_pc,
    output in_ready, out_valid, out_inst, out_comp, out_pc
  );

  modport master (
    output in_valid, in_data, out_ready, flush, flush_pc,
    input  in_ready, out_valid, out_inst, out_comp, out_pc
  );

endinterface

// File: rtl/fq_parcel_ram.sv
// Circular parcel store: up to two consecutive parcels written per cycle at wr_addr,
// and the two parcels at rd_addr / rd_addr+1 read combinationally.
module fq_parcel_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_lo_en,
  input  logic          wr_hi_en,
  input  logic [AW-1:0] wr_addr,
  input  parcel_t       wr_lo,
  input  parcel_t       wr_hi,
  input  logic [AW-1:0] rd_addr,
  output parcel_t       rd_lo,
  output parcel_t       rd_hi
);

  parcel_t       mem [DEPTH];
  logic [AW-1:0] wr_addr1;
  logic [AW-1:0] rd_addr1;

  // Power-of-two depth lets the pointer increment wrap for free.
  assign wr_addr1 = wr_addr + AW'(1);
  assign rd_addr1 = rd_addr + AW'(1);

  always_ff @(posedge clk) begin
    if (wr_lo_en) mem[wr_addr]  <= wr_lo;
    if (wr_hi_en) mem[wr_addr1] <= wr_hi;
  end

  assign rd_lo = mem[rd_addr];
  assign rd_hi = mem[rd_addr1];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: buffers aligned fetch words as parcels and issues
// realigned 16/32-bit instructions with their PCs; flush redirects to a new PC.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DEPTH    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic        clk,
  input logic        rst_n,
  fetch_queue_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d;
  logic            skip_lo_q, skip_lo_d;

  parcel_t         head_lo, head_hi;
  logic            head_comp;
  logic [CW-1:0]   need_n, in_n, out_n;
  logic            enq, deq, out_valid, in_ready;

  fq_parcel_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk      (clk),
    .wr_lo_en (enq),
    .wr_hi_en (enq & ~skip_lo_q),
    .wr_addr  (tail_q),
    .wr_lo    (skip_lo_q ? bus.in_data[31:16] : bus.in_data[15:0]),
    .wr_hi    (bus.in_data[31:16]),
    .rd_addr  (head_q),
    .rd_lo    (head_lo),
    .rd_hi    (head_hi)
  );

  assign head_comp = is_comp(head_lo);
  assign need_n    = head_comp ? CW'(1) : CW'(2);
  assign out_valid = count_q >= need_n;
  assign in_ready  = count_q <= CW'(DEPTH - 2);

  assign enq   = bus.in_valid & in_ready & ~bus.flush;
  assign deq   = out_valid & bus.out_ready & ~bus.flush;
  assign in_n  = enq ? (skip_lo_q ? CW'(1) : CW'(2)) : '0;
  assign out_n = deq ? need_n : '0;

  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    head_pc_d = head_pc_q;
    skip_lo_d = skip_lo_q;
    if (bus.flush) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      head_pc_d = bus.flush_pc & ~XLEN'(1);
      skip_lo_d = bus.flush_pc[1];
    end else begin
      count_d = count_q + in_n - out_n;
      tail_d  = tail_q + AW'(in_n);
      if (enq) skip_lo_d = 1'b0;
      if (deq) begin
        head_d    = head_q + AW'(need_n);
        head_pc_d = head_pc_q + (head_comp ? XLEN'(2) : XLEN'(4));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      head_pc_q <= RESET_PC;
      skip_lo_q <= RESET_PC[1];
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      head_pc_q <= head_pc_d;
      skip_lo_q <= skip_lo_d;
    end
  end

  // Nothing at the head reads as zero so stale RAM contents never leak out.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_comp  = out_valid & head_comp;
  assign bus.out_inst  = !out_valid ? 32'h0 :
                         head_comp  ? {16'h0, head_lo} : {head_hi, head_lo};
  assign bus.out_pc    = head_pc_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: DEPTH=8, RESET_PC=0x8000_0000.
module tb_fetch_queue;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fetch_queue_if #(.XLEN(64)) bus ();

  fetch_queue #(.XLEN(64), .DEPTH(8), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_head(input string tag, input logic v, input logic [31:0] inst,
                             input logic comp, input logic [63:0] pc);
    chk({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
    chk({tag, ".inst"},  64'(bus.out_inst),  64'(inst));
    chk({tag, ".comp"},  64'(bus.out_comp),  64'(comp));
    chk({tag, ".pc"},    bus.out_pc,         pc);
    $display("step %-10s valid=%0b inst=%h comp=%0b pc=%h", tag, bus.out_valid,
             bus.out_inst, bus.out_comp, bus.out_pc);
  endtask

  task automatic push(input logic [31:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic pop();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  function automatic logic [15:0] pa(input int n);
    return 16'((n << 4) | 1);
  endfunction

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    bus.flush_pc  = '0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    expect_head("reset", 1'b0, 32'h0, 1'b0, RPC);
    chk("reset.in_ready", 64'(bus.in_ready), 64'd1);

    // Single 32-bit instruction
    push(32'h00A00093);
    expect_head("w32", 1'b1, 32'h00A00093, 1'b0, RPC);
    pop();
    expect_head("w32.pop", 1'b0, 32'h0, 1'b0, RPC + 4);

    // Two compressed parcels from one word
    push(32'h00854501);
    expect_head("c0", 1'b1, 32'h4501, 1'b1, RPC + 4);
    pop();
    expect_head("c1", 1'b1, 32'h0085, 1'b1, RPC + 6);
    pop();
    chk("c.empty", 64'(bus.out_valid), 64'd0);

    // 32-bit instruction spanning two fetch words
    push(32'h00934505);
    expect_head("sp0", 1'b1, 32'h4505, 1'b1, RPC + 8);
    pop();
    expect_head("sp.hold", 1'b0, 32'h0, 1'b0, RPC + 10);
    push(32'h0000000A);
    expect_head("sp1", 1'b1, 32'h000A0093, 1'b0, RPC + 10);
    pop();
    expect_head("sp2", 1'b1, 32'h0, 1'b1, RPC + 14);
    pop();
    chk("sp.empty", 64'(bus.out_valid), 64'd0);

    // Fill with decode stalled: in_ready drops after four words
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("fill.rdy%0d", i), 64'(bus.in_ready), 64'd1);
      push({pa(2 * i + 1), pa(2 * i)});
    end
    chk("fill.full", 64'(bus.in_ready), 64'd0);
    for (int n = 0; n < 8; n++) begin
      expect_head($sformatf("drain%0d", n), 1'b1, {16'h0, pa(n)}, 1'b1, RPC + 16 + 2 * n);
      pop();
    end
    expect_head("drain.empty", 1'b0, 32'h0, 1'b0, RPC + 32);

    // Second fill with a one-parcel offset so data and head wrap
    push(32'h00134501);
    expect_head("wr.c", 1'b1, 32'h4501, 1'b1, RPC + 32);
    pop();
    chk("wr.hold", 64'(bus.out_valid), 64'd0);
    push(32'h00930200);
    push(32'h00130300);
    push(32'h00010400);
    chk("wr.full", 64'(bus.in_ready), 64'd0);
    expect_head("wr.i1", 1'b1, 32'h02000013, 1'b0, RPC + 34);
    pop();
    chk("wr.rdy", 64'(bus.in_ready), 64'd1);
    push(32'h00000500);
    expect_head("wr.i2", 1'b1, 32'h03000093, 1'b0, RPC + 38);
    pop();
    expect_head("wr.i3", 1'b1, 32'h04000013, 1'b0, RPC + 42);
    pop();
    expect_head("wr.i4", 1'b1, 32'h00000001, 1'b1, RPC + 46);
    pop();
    expect_head("wr.i5", 1'b1, 32'h00000500, 1'b1, RPC + 48);
    pop();
    expect_head("wr.i6", 1'b1, 32'h00000000, 1'b1, RPC + 50);
    pop();
    chk("wr.empty", 64'(bus.out_valid), 64'd0);

    // Flush with six parcels queued and both handshakes offered
    push(32'h11111111);
    push(32'h11111111);
    push(32'h11111111);
    bus.flush     = 1'b1;
    bus.flush_pc  = 64'h8000_0103;
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'hDEADBEEF;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    expect_head("fl", 1'b0, 32'h0, 1'b0, 64'h8000_0102);
    chk("fl.in_ready", 64'(bus.in_ready), 64'd1);
    push(32'h00934501);
    expect_head("fl.skip", 1'b0, 32'h0, 1'b0, 64'h8000_0102);
    push(32'h0000000A);
    expect_head("fl.i0", 1'b1, 32'h000A0093, 1'b0, 64'h8000_0102);
    pop();
    expect_head("fl.i1", 1'b1, 32'h0, 1'b1, 64'h8000_0106);
    pop();

    // Asynchronous reset mid-stream with in_valid held
    push(32'h00A00093);
    chk("rs.pre", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h00A00093;
    #2 rst_n = 1'b0;
    #1;
    expect_head("rs", 1'b0, 32'h0, 1'b0, RPC);
    chk("rs.in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    expect_head("rs.post", 1'b0, 32'h0, 1'b0, RPC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
